// File: rtl/order_dispatcher_pkg.sv
// Shared codes for the order dispatcher: message types, sides,
// engine index encoding and dispatcher state encodings.
package order_dispatcher_pkg;

    typedef enum logic [1:0] {
        MSG_ADD     = 2'b00,
        MSG_CANCEL  = 2'b01,
        MSG_EXECUTE = 2'b10,
        MSG_RSVD    = 2'b11
    } msg_type_t;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    localparam logic [1:0] ENG_BUY_ADD  = 2'd0;
    localparam logic [1:0] ENG_BUY_DEC  = 2'd1;
    localparam logic [1:0] ENG_SELL_ADD = 2'd2;
    localparam logic [1:0] ENG_SELL_DEC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } disp_state_t;

    // CANCEL and EXECUTE both shrink the book, so they share the decrease engine
    function automatic logic [1:0] eng_index(input logic side, input msg_type_t t);
        return {side, t != MSG_ADD};
    endfunction

endpackage

// File: rtl/order_dispatcher_watchdog.sv
// Engine watchdog: cycle counter with clear, pulses tc at TIMEOUT-1.
module engine_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/order_dispatcher.sv
// Order dispatcher: routes book messages to add/decrease engines,
// owns per-side size and best price, publishes top-of-book.
module order_dispatcher
    import order_dispatcher_pkg::*;
#(
    parameter int ORDER_W    = 8,
    parameter int QTY_W      = 8,
    parameter int PRICE_W    = 16,
    parameter int SIZE_W     = 8,
    parameter int MAX_ORDERS = 255,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [1:0]           msg_type,
    input  logic                 msg_side,
    input  logic [ORDER_W-1:0]   msg_id,
    input  logic [QTY_W-1:0]     msg_qty,
    input  logic [PRICE_W-1:0]   msg_price,
    output logic [3:0]           start_o,
    output logic [ORDER_W-1:0]   id_o,
    output logic [QTY_W-1:0]     qty_o,
    output logic [PRICE_W-1:0]   price_o,
    output logic                 delete_o,
    output logic [SIZE_W-1:0]    size_o,
    output logic [PRICE_W-1:0]   best_price_o,
    input  logic [3:0]           done_i,
    input  logic [4*SIZE_W-1:0]  size_upd_i,
    input  logic [4*PRICE_W-1:0] bp_i,
    output logic                 tob_valid,
    output logic [PRICE_W-1:0]   buy_best,
    output logic [PRICE_W-1:0]   sell_best,
    output logic [SIZE_W-1:0]    buy_size,
    output logic [SIZE_W-1:0]    sell_size,
    output logic                 err_o
);

    disp_state_t state, state_nx;
    msg_type_t   type_q;
    logic        side_q;
    logic [1:0]  eng_q;
    logic        err_q;
    logic        tc;

    logic        fire;
    logic        reject;
    logic        done_sel;
    logic [SIZE_W-1:0]  side_size_in;
    logic [SIZE_W-1:0]  upd_size;
    logic [PRICE_W-1:0] upd_bp;

    assign msg_ready    = (state == ST_IDLE) && !rst;
    assign fire         = msg_valid && msg_ready;
    assign side_size_in = msg_side ? sell_size : buy_size;

    assign reject = (msg_type == MSG_RSVD) ||
                    ((msg_type == MSG_ADD) &&
                     ((msg_price == '0) ||
                      (32'(side_size_in) >= MAX_ORDERS)));

    assign done_sel = done_i[eng_q];
    assign upd_size = size_upd_i[eng_q*SIZE_W +: SIZE_W];
    assign upd_bp   = bp_i[eng_q*PRICE_W +: PRICE_W];

    assign start_o      = (state == ST_ISSUE && !rst) ? (4'b0001 << eng_q) : 4'b0000;
    assign delete_o     = (type_q == MSG_CANCEL);
    assign size_o       = side_q ? sell_size : buy_size;
    assign best_price_o = side_q ? sell_best : buy_best;
    assign tob_valid    = (state == ST_COMMIT) && !rst;

    // A late done in the timeout cycle still commits, so it masks the abort
    assign err_o = !rst && (err_q || ((state == ST_WAIT) && tc && !done_sel));

    engine_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk_in),
        .rst   (rst),
        .clear (state == ST_ISSUE),
        .en    (state == ST_WAIT),
        .tc    (tc)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (fire && !reject) state_nx = ST_ISSUE;
            ST_ISSUE:  state_nx = ST_WAIT;
            ST_WAIT: begin
                if (done_sel)  state_nx = ST_COMMIT;
                else if (tc)   state_nx = ST_IDLE;
            end
            ST_COMMIT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            type_q    <= MSG_ADD;
            side_q    <= 1'b0;
            eng_q     <= 2'd0;
            err_q     <= 1'b0;
            id_o      <= '0;
            qty_o     <= '0;
            price_o   <= '0;
            buy_best  <= '0;
            sell_best <= '0;
            buy_size  <= '0;
            sell_size <= '0;
        end else begin
            state <= state_nx;
            err_q <= fire && reject;
            if (fire) begin
                type_q  <= msg_type_t'(msg_type);
                side_q  <= msg_side;
                eng_q   <= eng_index(msg_side, msg_type_t'(msg_type));
                id_o    <= msg_id;
                qty_o   <= msg_qty;
                price_o <= msg_price;
            end
            if (state == ST_WAIT && done_sel) begin
                if (side_q == SIDE_SELL) begin
                    sell_size <= upd_size;
                    sell_best <= upd_bp;
                end else begin
                    buy_size <= upd_size;
                    buy_best <= upd_bp;
                end
            end
        end
    end

endmodule

// File: tb/tb_order_dispatcher.sv
// Directed bench for order_dispatcher with a bench-side engine model
// and a scoreboard of expected snapshot/error events.
module tb_order_dispatcher;
    import order_dispatcher_pkg::*;

    typedef struct packed {
        logic        is_err;
        logic [15:0] bb;
        logic [7:0]  bs;
        logic [15:0] sb;
        logic [7:0]  ss;
    } ev_t;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_type;
    logic        msg_side;
    logic [7:0]  msg_id;
    logic [7:0]  msg_qty;
    logic [15:0] msg_price;
    logic [3:0]  start_o;
    logic [7:0]  id_o;
    logic [7:0]  qty_o;
    logic [15:0] price_o;
    logic        delete_o;
    logic [7:0]  size_o;
    logic [15:0] best_price_o;
    logic [3:0]  done_i;
    logic [31:0] size_upd_i;
    logic [63:0] bp_i;
    logic        tob_valid;
    logic [15:0] buy_best;
    logic [15:0] sell_best;
    logic [7:0]  buy_size;
    logic [7:0]  sell_size;
    logic        err_o;

    order_dispatcher dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_type     (msg_type),
        .msg_side     (msg_side),
        .msg_id       (msg_id),
        .msg_qty      (msg_qty),
        .msg_price    (msg_price),
        .start_o      (start_o),
        .id_o         (id_o),
        .qty_o        (qty_o),
        .price_o      (price_o),
        .delete_o     (delete_o),
        .size_o       (size_o),
        .best_price_o (best_price_o),
        .done_i       (done_i),
        .size_upd_i   (size_upd_i),
        .bp_i         (bp_i),
        .tob_valid    (tob_valid),
        .buy_best     (buy_best),
        .sell_best    (sell_best),
        .buy_size     (buy_size),
        .sell_size    (sell_size),
        .err_o        (err_o)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int tob_cyc = 0;
    int err_cyc = 0;
    int s_cyc = 0;
    ev_t exp_q[$];

    int          eng_cnt = 0;
    int          eng_lat = 0;
    logic [1:0]  eng_e = 2'd0;
    logic [7:0]  eng_size = 8'd0;
    logic [15:0] eng_bp = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic e, input logic [15:0] bb, input logic [7:0] bs,
                        input logic [15:0] sb, input logic [7:0] ss);
        ev_t ev;
        ev = {e, bb, bs, sb, ss};
        exp_q.push_back(ev);
    endtask

    // One clock: engine model responds, then events are scored.
    task automatic tick();
        ev_t obs;
        ev_t ex;
        @(posedge clk_in);
        #1;
        cyc++;
        done_i = 4'b0000;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                done_i[eng_e] = 1'b1;
                size_upd_i[eng_e*8 +: 8] = eng_size;
                bp_i[eng_e*16 +: 16] = eng_bp;
            end
        end
        if (start_o != 4'b0000) begin
            start_cyc = cyc;
            for (int i = 0; i < 4; i++) begin
                if (start_o[i]) eng_e = 2'(i);
            end
            if (eng_lat > 0) eng_cnt = eng_lat;
        end
        if (tob_valid || err_o) begin
            obs = {err_o, buy_best, buy_size, sell_best, sell_size};
            if (tob_valid) tob_cyc = cyc;
            if (err_o) err_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 64'(exp_q.size()), 64'(1));
            end else begin
                ex = exp_q.pop_front();
                chk("event", 64'(obs), 64'(ex));
            end
        end
    endtask

    task automatic send(input logic [1:0] t, input logic s, input logic [7:0] id,
                        input logic [7:0] q, input logic [15:0] p);
        msg_type  = t;
        msg_side  = s;
        msg_id    = id;
        msg_qty   = q;
        msg_price = p;
        msg_valid = 1'b1;
        chk("send_ready", 64'(msg_ready), 64'(1));
        tick();
        msg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (msg_ready === 1'b1 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 64'(ok), 64'(1));
    endtask

    initial begin
        rst        = 1'b1;
        msg_valid  = 1'b0;
        msg_type   = 2'b00;
        msg_side   = 1'b0;
        msg_id     = 8'd0;
        msg_qty    = 8'd0;
        msg_price  = 16'd0;
        done_i     = 4'b0000;
        size_upd_i = 32'd0;
        bp_i       = 64'd0;

        tick();
        tick();
        chk("reset_outputs",
            {msg_ready, start_o, id_o, qty_o, price_o, delete_o,
             size_o, best_price_o, tob_valid, err_o}, 64'd0);
        chk("reset_book", 64'({buy_best, sell_best, buy_size, sell_size}), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(msg_ready), 64'(1));

        // ADD buy id=5 qty=10 price=100
        eng_lat = 3; eng_size = 8'd1; eng_bp = 16'd100;
        push(1'b0, 16'd100, 8'd1, 16'd0, 8'd0);
        send(MSG_ADD, SIDE_BUY, 8'd5, 8'd10, 16'd100);
        chk("add_start", 64'(start_o), 64'(4'b0001 << ENG_BUY_ADD));
        chk("add_fields", 64'({id_o, qty_o, price_o, delete_o}),
            64'({8'd5, 8'd10, 16'd100, 1'b0}));
        chk("add_ready_low", 64'(msg_ready), 64'(0));
        s_cyc = cyc;
        wait_idle("add_done");
        chk("add_latency", 64'(tob_cyc - s_cyc), 64'(4));

        // CANCEL buy id=5
        eng_lat = 3; eng_size = 8'd0; eng_bp = 16'd0;
        push(1'b0, 16'd0, 8'd0, 16'd0, 8'd0);
        send(MSG_CANCEL, SIDE_BUY, 8'd5, 8'd0, 16'd0);
        chk("cancel_start", 64'(start_o), 64'(4'b0001 << ENG_BUY_DEC));
        chk("cancel_fields", 64'({delete_o, size_o, best_price_o}),
            64'({1'b1, 8'd1, 16'd100}));
        wait_idle("cancel_done");

        // ADD sell with price 0 is rejected
        push(1'b1, 16'd0, 8'd0, 16'd0, 8'd0);
        send(MSG_ADD, SIDE_SELL, 8'd7, 8'd4, 16'd0);
        chk("zero_price_err_cyc", 64'(err_cyc), 64'(cyc));
        chk("zero_price_no_start", 64'(start_o), 64'(0));
        chk("zero_price_ready", 64'(msg_ready), 64'(1));
        wait_idle("zero_price_done");

        // Reserved type is rejected
        push(1'b1, 16'd0, 8'd0, 16'd0, 8'd0);
        send(MSG_RSVD, SIDE_BUY, 8'd1, 8'd1, 16'd55);
        chk("rsvd_no_start", 64'(start_o), 64'(0));
        wait_idle("rsvd_done");

        // Preload sell side, then EXECUTE that never completes
        eng_lat = 2; eng_size = 8'd1; eng_bp = 16'd200;
        push(1'b0, 16'd0, 8'd0, 16'd200, 8'd1);
        send(MSG_ADD, SIDE_SELL, 8'd9, 8'd5, 16'd200);
        chk("sell_add_start", 64'(start_o), 64'(4'b0001 << ENG_SELL_ADD));
        wait_idle("sell_add_done");

        eng_lat = 0;
        push(1'b1, 16'd0, 8'd0, 16'd200, 8'd1);
        send(MSG_EXECUTE, SIDE_SELL, 8'd9, 8'd3, 16'd0);
        chk("exec_start", 64'(start_o), 64'(4'b0001 << ENG_SELL_DEC));
        chk("exec_fields", 64'({delete_o, size_o, best_price_o, qty_o}),
            64'({1'b0, 8'd1, 16'd200, 8'd3}));
        s_cyc = cyc;
        wait_idle("exec_done");
        chk("timeout_latency", 64'(err_cyc - s_cyc), 64'(64));
        chk("timeout_book", 64'({sell_best, sell_size}), 64'({16'd200, 8'd1}));

        // Held message during WAIT; first fills buy side to capacity
        eng_lat = 3; eng_size = 8'd255; eng_bp = 16'd300;
        push(1'b0, 16'd300, 8'd255, 16'd200, 8'd1);
        push(1'b1, 16'd300, 8'd255, 16'd200, 8'd1);
        send(MSG_ADD, SIDE_BUY, 8'd7, 8'd1, 16'd300);
        msg_valid = 1'b1;
        msg_id    = 8'd8;
        msg_price = 16'd310;
        tick();
        chk("hold_wait_ready", 64'(msg_ready), 64'(0));
        for (int i = 0; i < 20; i++) begin
            if (tob_valid === 1'b1) break;
            tick();
        end
        chk("hold_commit", 64'({tob_valid, msg_ready}), 64'({1'b1, 1'b0}));
        tick();
        chk("hold_ready_again", 64'(msg_ready), 64'(1));
        tick();
        msg_valid = 1'b0;
        chk("full_err_cyc", 64'(err_cyc), 64'(cyc));
        chk("full_no_start", 64'(start_o), 64'(0));
        wait_idle("full_done");

        // Reset while in WAIT; the engine's late done must be ignored
        eng_lat = 5; eng_size = 8'd9; eng_bp = 16'd50;
        send(MSG_ADD, SIDE_SELL, 8'd3, 8'd2, 16'd50);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_high_ready", 64'({msg_ready, start_o}), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("rst_outputs",
            {msg_ready, start_o, id_o, qty_o, price_o, delete_o,
             size_o, best_price_o, tob_valid, err_o}, {1'b1, 63'd0});
        chk("rst_book", 64'({buy_best, sell_best, buy_size, sell_size}), 64'd0);
        repeat (8) tick();
        chk("late_done_book", 64'({buy_best, sell_best, buy_size, sell_size}), 64'd0);
        chk("late_done_idle", 64'({msg_ready, start_o}), 64'({1'b1, 4'b0000}));

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
